match_report_scheduler: RTL
===========================

Name: match_report_scheduler

Overview:
Sequences reporting for the bank of matched filters. Tracks each filter's peak score and sample position over one filter pass, and picks the winning filter. Then owns the shared UART transmitter and serialises one result frame per pass. Sits between the matched_filter instances and the uart instance, downstream of the capture/filter sequencer, which supplies pass_start/pass_end.

Parameters:
NUM_FILTERS, 2, number of matched filters reported (1..8)
SCORE_WIDTH, 32, width of each signed match score; must be 32 for the frame format
IDX_WIDTH, 16, width of per-filter sample index; must be 16 for the frame format

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pass_start  in  1  one-cycle pulse: a new filter pass begins
pass_end  in  1  one-cycle pulse: the current pass is complete
score_valid  in  NUM_FILTERS  per-filter score strobe (filter axiov)
score_data  in  NUM_FILTERS*SCORE_WIDTH  packed signed scores; filter i occupies bits [i*SCORE_WIDTH +: SCORE_WIDTH]
uart_ready  in  1  UART idle and able to accept a byte
uart_valid  out  1  byte strobe to UART
uart_data  out  8  byte to UART
busy  out  1  high in the TRACK and SEND states
winner  out  $clog2(NUM_FILTERS) (min 1)  index of the filter with the highest peak, valid from winner_valid onward
winner_valid  out  1  one-cycle pulse at the end of each pass

Behaviour:
- Reset: state IDLE. All outputs 0. Peaks are set to the most negative value, indices and counters to 0, and pass_count to 0. A reset during SEND drops uart_valid on the next edge and abandons the frame.
- States:
  - IDLE: pass_start -> TRACK. pass_end is ignored.
  - TRACK: pass_end -> SEND. pass_end takes priority over a simultaneous pass_start. A pass_start alone restarts the pass and clears all trackers.
  - SEND: the last frame byte is accepted -> IDLE. pass_start is ignored.
- Entering TRACK (from IDLE or on restart): each peak is set to -2^(SCORE_WIDTH-1), and peak_idx and sample_cnt are set to 0.
- Peak tracking, per filter and independent, on each score_valid[i] in TRACK:
  - Compare signed. If score > peak (strictly greater), then peak <= score and peak_idx <= sample_cnt. Ties keep the earlier index.
  - sample_cnt increments and saturates at 2^IDX_WIDTH-1.
  - Strobes in IDLE or SEND are ignored.
  - A strobe in the same cycle as pass_end is included in the result.
- At pass_end:
  - Snapshot all peaks and indices into the frame registers.
  - Compute winner: highest peak, lowest filter index on a tie.
  - winner_valid pulses on the cycle after pass_end, together with the TRACK->SEND transition.
  - pass_count increments (8-bit, wraps) after it is sent.
- UART handshake: in SEND, when uart_ready=1 and uart_valid=0, assert uart_valid for exactly one cycle with uart_data set to the current byte, then advance the byte pointer. uart_valid is never high for two consecutive cycles.
- Frame, bytes in order:
  - 0xA5
  - pass_count
  - for each filter i = 0..N-1: i, score[31:24], score[23:16], score[15:8], score[7:0], idx[15:8], idx[7:0]
- Frame length is 2+7*NUM_FILTERS bytes, or 3+7*NUM_FILTERS with the checksum enabled.
- SEND->IDLE occurs on the cycle after the last uart_valid pulse.

Optional Feature:
- Macro REPORT_CHECKSUM_EN.
  - Defined: append one byte equal to the XOR of all frame bytes after 0xA5 (pass_count through the last index byte).
  - Undefined: no checksum byte, and no checksum register is synthesised.

Decomposition:
- Package filter_report_pkg holds:
  - SYNC_BYTE = 8'hA5
  - BYTES_PER_FILTER = 7
  - the state enum typedef report_state_t {IDLE, TRACK, SEND}
- Sub-module peak_tracker, instantiated NUM_FILTERS times: clear, valid, signed score in; peak and peak_idx out; holds the saturating counter.
- The top level holds the FSM, the winner comparator, the byte mux and the handshake.

Test Plan:
- Peak and tie handling, N=2, checksum off: pass_start; filter0 scores 5,-3,9,9,2; filter1 scores -10,-20; pass_end.
  - Frame: A5 00 | 00 00 00 00 09 00 02 | 01 FF FF FF F6 00 00.
  - winner=0, winner_valid pulses once.
- Handshake: hold uart_ready=0 for 50 cycles mid-frame -> uart_valid stays 0, no bytes lost. Every uart_valid pulse is exactly 1 cycle long and coincides with uart_ready=1.
- No samples: pass_start then pass_end with no strobes.
  - Each filter reports score 80 00 00 00 and idx 00 00.
  - winner=0 (tie, lowest index).
- Event collisions:
  - pass_start during SEND -> ignored; the frame completes and the state returns to IDLE.
  - pass_start and pass_end together in TRACK -> SEND.
  - Strobe coincident with pass_end -> that score is included.
- Reset mid-SEND after 4 bytes -> uart_valid=0 and busy=0 on the next cycle. The next pass's frame starts at A5 00.
- With REPORT_CHECKSUM_EN, repeat the first scenario -> the trailing byte equals the XOR of the 15 bytes after A5. Two consecutive passes carry pass_count 00 then 01.

Source files
------------

// File: rtl/filter_report_pkg.sv
// Shared constants and state type for the matched-filter report scheduler.
package filter_report_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam int         BYTES_PER_FILTER = 7;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        SEND
    } report_state_t;

endpackage

// File: rtl/peak_tracker.sv
// Per-filter running maximum of a signed score, with the index of its first occurrence.
module peak_tracker #(
    parameter int SCORE_WIDTH = 32,
    parameter int IDX_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   valid,
    input  logic [SCORE_WIDTH-1:0] score,
    output logic [SCORE_WIDTH-1:0] peak,
    output logic [IDX_WIDTH-1:0]   peak_idx
);

    localparam logic [SCORE_WIDTH-1:0] MOST_NEG = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    logic [SCORE_WIDTH-1:0] peak_q, peak_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;

    always_comb begin
        peak_d = peak_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        if (clear) begin
            peak_d = MOST_NEG;
            idx_d  = '0;
            cnt_d  = '0;
        end else if (valid) begin
            // strictly greater, so a tie keeps the earlier index
            if ($signed(score) > $signed(peak_q)) begin
                peak_d = score;
                idx_d  = cnt_q;
            end
            if (cnt_q != {IDX_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= MOST_NEG;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            peak_q <= peak_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

    assign peak     = peak_q;
    assign peak_idx = idx_q;

endmodule

// File: rtl/match_report_scheduler.sv
// Tracks per-filter peaks over a pass, picks the winner and sends one UART frame per pass.
// Optional trailing XOR checksum byte enabled by REPORT_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for pass_start
// TRACK | pass in progress, trackers follow score strobes
// SEND  | trackers frozen, frame being serialised to the UART
module match_report_scheduler
    import filter_report_pkg::*;
#(
    parameter int NUM_FILTERS = 2,
    parameter int SCORE_WIDTH = 32,
    parameter int IDX_WIDTH   = 16,
    localparam int WIN_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pass_start,
    input  logic                               pass_end,
    input  logic [NUM_FILTERS-1:0]             score_valid,
    input  logic [NUM_FILTERS*SCORE_WIDTH-1:0] score_data,
    input  logic                               uart_ready,
    output logic                               uart_valid,
    output logic [7:0]                         uart_data,
    output logic                               busy,
    output logic [WIN_W-1:0]                   winner,
    output logic                               winner_valid
);

`ifdef REPORT_CHECKSUM_EN
    localparam int FRAME_LEN = 3 + BYTES_PER_FILTER * NUM_FILTERS;
`else
    localparam int FRAME_LEN = 2 + BYTES_PER_FILTER * NUM_FILTERS;
`endif

    report_state_t state_q, state_d;
    logic [7:0]       ptr_q, ptr_d;
    logic [7:0]       pc_q, pc_d;
    logic             uv_q, uv_d;
    logic [7:0]       ud_q, ud_d;
    logic             wv_q, wv_d;
    logic [WIN_W-1:0] winner_q, winner_d;
`ifdef REPORT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic [SCORE_WIDTH-1:0] peak [NUM_FILTERS];
    logic [IDX_WIDTH-1:0]   pidx [NUM_FILTERS];
    logic                   track_clear;
    logic [WIN_W-1:0]       win_comb;
    logic [SCORE_WIDTH-1:0] best;
    logic [7:0]             cur_byte;
    logic [7:0]             k;
    logic [7:0]             off;

    assign track_clear = ((state_q == IDLE) && pass_start) ||
                         ((state_q == TRACK) && pass_start && !pass_end);

    // Trackers only move in TRACK, so in SEND their outputs are the pass snapshot.
    for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_trk
        peak_tracker #(
            .SCORE_WIDTH(SCORE_WIDTH),
            .IDX_WIDTH  (IDX_WIDTH)
        ) u_trk (
            .clk     (clk),
            .rst     (rst),
            .clear   (track_clear),
            .valid   ((state_q == TRACK) && score_valid[g]),
            .score   (score_data[g*SCORE_WIDTH +: SCORE_WIDTH]),
            .peak    (peak[g]),
            .peak_idx(pidx[g])
        );
    end

    always_comb begin
        best     = peak[0];
        win_comb = '0;
        for (int i = 1; i < NUM_FILTERS; i++) begin
            if ($signed(peak[i]) > $signed(best)) begin
                best     = peak[i];
                win_comb = WIN_W'(i);
            end
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        off      = 8'h00;
        k        = ptr_q - 8'd2;
        if (ptr_q == 8'd0) begin
            cur_byte = SYNC_BYTE;
        end else if (ptr_q == 8'd1) begin
            cur_byte = pc_q;
        end else begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                if ((k >= 8'(i * BYTES_PER_FILTER)) && (k < 8'((i + 1) * BYTES_PER_FILTER))) begin
                    off = k - 8'(i * BYTES_PER_FILTER);
                    case (off)
                        8'd0:    cur_byte = 8'(i);
                        8'd1:    cur_byte = peak[i][31:24];
                        8'd2:    cur_byte = peak[i][23:16];
                        8'd3:    cur_byte = peak[i][15:8];
                        8'd4:    cur_byte = peak[i][7:0];
                        8'd5:    cur_byte = pidx[i][15:8];
                        default: cur_byte = pidx[i][7:0];
                    endcase
                end
            end
`ifdef REPORT_CHECKSUM_EN
            if (ptr_q == 8'(FRAME_LEN - 1)) begin
                cur_byte = csum_q;
            end
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pc_d     = pc_q;
        uv_d     = 1'b0;
        ud_d     = ud_q;
        wv_d     = 1'b0;
        winner_d = winner_q;
`ifdef REPORT_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (pass_start) state_d = TRACK;
            end
            TRACK: begin
                if (pass_end) begin
                    state_d = SEND;
                    wv_d    = 1'b1;
                    ptr_d   = 8'd0;
`ifdef REPORT_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            SEND: begin
                winner_d = win_comb;
                if (uv_q && (ptr_q == 8'(FRAME_LEN))) begin
                    state_d = IDLE;
                    pc_d    = pc_q + 8'd1;
                end else if (uart_ready && !uv_q) begin
                    uv_d  = 1'b1;
                    ud_d  = cur_byte;
                    ptr_d = ptr_q + 8'd1;
`ifdef REPORT_CHECKSUM_EN
                    if (ptr_q != 8'd0) csum_d = csum_q ^ cur_byte;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            pc_q     <= '0;
            uv_q     <= 1'b0;
            ud_q     <= '0;
            wv_q     <= 1'b0;
            winner_q <= '0;
`ifdef REPORT_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            pc_q     <= pc_d;
            uv_q     <= uv_d;
            ud_q     <= ud_d;
            wv_q     <= wv_d;
            winner_q <= winner_d;
`ifdef REPORT_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // The frozen trackers already hold the result on the winner_valid cycle.
    assign winner       = (state_q == SEND) ? win_comb : winner_q;
    assign busy         = (state_q != IDLE);
    assign uart_valid   = uv_q;
    assign uart_data    = ud_q;
    assign winner_valid = wv_q;

endmodule
